instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the decode logic inside `CPU`. It owns the program counter, issues in-order word requests to instruction memory over a request/grant interface, buffers returned instructions in a small queue, and presents them to decode with a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard in-flight responses before fetching from the new target.

## Interface
- `ADDR_W`, 32, PC / instruction-memory address width
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, fetch queue entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset; word-aligned
- `CLK`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  request valid
- `imem_addr`  out  ADDR_W  request word address (byte address, bits [1:0]=0)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; responses return in request order
- `imem_rdata`  in  DATA_W  response instruction
- `redirect`  in  1  flush and restart fetch
- `redirect_pc`  in  ADDR_W  new fetch target; bits [1:0] ignored (forced 0)
- `if_valid`  out  1  head instruction valid to decode
- `if_instr`  out  DATA_W  head instruction
- `if_pc`  out  ADDR_W  PC of head instruction
- `id_ready`  in  1  decode accepts head this cycle

## Operation
- State: `fetch_pc`, `resp_pc`, queue (`DEPTH` entries of {pc, instr}), `outstanding` counter ($clog2(DEPTH)+1 bits), FSM {RUN, FLUSH}.
- Reset: FSM=RUN, `fetch_pc`=`resp_pc`=RESET_PC, queue empty, `outstanding`=0. Outputs: `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- RUN: `imem_req`=1 iff queue_count + `outstanding` < DEPTH (credit rule; queue can never overflow). `imem_addr`=`fetch_pc`. On `imem_req && imem_gnt`: `fetch_pc` += 4, `outstanding` += 1.
- Response in RUN: `imem_rvalid` writes {`resp_pc`, `imem_rdata`} to queue tail, `resp_pc` += 4, `outstanding` −= 1. Simultaneous grant and response: net `outstanding` unchanged.
- Pop: `if_valid && id_ready` removes head. Push and pop same cycle allowed at any occupancy, including full.
- `redirect` (either state): queue cleared, `fetch_pc`=`resp_pc`={redirect_pc[ADDR_W-1:2],2'b00}; if `outstanding` after this cycle's grant/response accounting is nonzero → FLUSH, else RUN. `if_valid` is masked to 0 in the redirect cycle, so no pop occurs. A grant in the redirect cycle is counted and later discarded; a response in the redirect cycle is discarded.
- FLUSH: `imem_req`=0; each `imem_rvalid` is dropped and decrements `outstanding`; when it reaches 0 → RUN. A further `redirect` in FLUSH only updates target PCs.
- PC arithmetic wraps modulo 2^ADDR_W.
- `imem_rvalid` with `outstanding`=0 is a protocol error; ignored (assertion in bench).

## Timing
- `imem_req`/`imem_addr` are held stable until `imem_gnt`, except when aborted by `redirect`.
- Response earliest one cycle after its grant.
- `imem_rvalid` at cycle t → `if_valid` at t+1 (registered queue, no bypass).
- Redirect at cycle t with `outstanding`=0 → `imem_req`=1, `imem_addr`=target at t+1.
- Sustained throughput: one instruction/cycle with single-cycle memory and `id_ready`=1.
- `Reset` asserted mid-operation: immediate return to reset values regardless of state or handshakes.

## Structure
- `fetch_pkg`: `fetch_entry_t` struct {pc, instr}, `fetch_state_t` enum {RUN, FLUSH}, `INSTR_BYTES`=4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter DEPTH, push/pop/clear, count, async reset; `instr_fetch` holds PC, credit and FSM logic.

## Test plan
- Reset, memory grants every cycle with 1-cycle response, `id_ready`=1 → addresses 0x0,0x4,0x8…; `if_pc` 0x0 first valid 3 cycles after reset release, then one per cycle.
- `id_ready`=0 forever → exactly 4 requests granted, `imem_req` then stays 0, queue holds PCs 0x0–0xC.
- Redirect to 0x103 with 2 responses outstanding → both dropped, no `if_valid`, next `imem_addr`=0x100, first `if_pc`=0x100.
- Redirect in same cycle as `imem_rvalid` and `id_ready`=1 with nonempty queue → no pop, response dropped, queue empty next cycle.
- Second redirect (to 0x200) during FLUSH → first target never fetched, fetch resumes at 0x200.
- `fetch_pc`=0xFFFFFFFC → next request 0x00000000; `Reset` pulse mid-burst → outputs return to reset values same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_entry_t : one fetch-queue entry {pc, instr}
//   fetch_state_t : fetch control state (RUN, FLUSH)
//   INSTR_BYTES   : PC increment per fetched instruction
// Entry fields are sized for the widest supported PC / instruction (32 bits);
// narrower instantiations zero-extend into them.
package fetch_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   CLK, Reset : clock, asynchronous active-high reset (pointers/count only)
//   push/wdata : write entry at tail
//   pop/rdata  : remove head; rdata always shows the current head slot
//   clear      : drop all entries (wins over push/pop)
//   count      : number of valid entries, 0..DEPTH
// Push while full is accepted only together with a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the program counter, issues in-order word requests to instruction
// memory, buffers responses in a fetch queue and hands them to decode.
//   CLK, Reset             : clock, asynchronous active-high reset
//   imem_req/addr/gnt      : request/grant interface to instruction memory
//   imem_rvalid/rdata      : in-order responses
//   redirect/redirect_pc   : flush and restart fetch at a new target
//   if_valid/instr/pc      : head instruction to decode
//   id_ready               : decode accepts the head this cycle
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  q_count;
  logic              req_en;
  logic              credit_ok;
  logic              grant;
  logic              resp;
  logic              q_push;
  logic              q_pop;
  logic              q_nonempty;
  fetch_entry_t      q_wdata;
  fetch_entry_t      q_rdata;

  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Credit: never have more entries in flight plus queued than queue slots,
  // so a response always finds room.
  assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);

  assign grant           = imem_req && imem_gnt;
  assign resp            = imem_rvalid && (outstanding != '0);
  assign outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(resp);

  assign q_nonempty = (q_count != '0);
  assign if_valid   = q_nonempty && !redirect;
  assign q_pop      = if_valid && id_ready;
  assign q_push     = resp && (state == RUN) && !redirect;

  assign q_wdata.pc    = FETCH_ADDR_W'(resp_pc);
  assign q_wdata.instr = FETCH_DATA_W'(imem_rdata);

  assign imem_addr = fetch_pc;
  assign if_instr  = q_nonempty ? DATA_W'(q_rdata.instr) : '0;
  assign if_pc     = q_nonempty ? ADDR_W'(q_rdata.pc) : '0;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count)
  );

  // Control: next state and request
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    if (state == RUN) imem_req = req_en && credit_ok;
    if (redirect) begin
      state_nxt = (outstanding_nxt != '0) ? FLUSH : RUN;
    end else if ((state == FLUSH) && (outstanding_nxt == '0)) begin
      state_nxt = RUN;
    end
  end

  // Registered state: FSM, PCs, in-flight count
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      req_en      <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      req_en      <= 1'b1;
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (grant)  fetch_pc <= fetch_pc + PC_STEP;
        if (q_push) resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, memory responder model,
// scoreboard of expected fetched PCs checked by an independent monitor.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  logic        mem_hold;
  logic [31:0] pend[$];
  logic [31:0] exp_pc[$];
  int          tests = 0;
  int          fails = 0;
  int          ngr;

  instr_fetch dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // Memory: records granted addresses, answers one per cycle in order,
  // earliest the cycle after the grant; mem_hold stalls responses.
  always @(negedge CLK) begin
    if (Reset) begin
      pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req && imem_gnt) pend.push_back(imem_addr);
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!mem_hold && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    logic [31:0] p;
    if (!Reset && if_valid && id_ready) begin
      if (exp_pc.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got if_pc=%h, required no instruction", if_pc);
      end else begin
        p = exp_pc.pop_front();
        check("sb_pc", if_pc, p);
        check("sb_instr", if_instr, memword(p));
      end
    end
  end

  initial begin
    Reset = 1'b0; imem_gnt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    id_ready = 1'b0; mem_hold = 1'b0;
    #1 Reset = 1'b1;
    repeat (2) tick();
    at_neg();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc",    if_pc, 32'd0);

    // Streaming: 8 grants, 1-cycle memory, decode always ready
    for (int i = 0; i < 8; i++) exp_pc.push_back(32'(i * 4));
    tick(); Reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    at_neg();
    check("rel_req", {31'd0, imem_req}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 9) imem_gnt = 1'b0;
      at_neg();
      if (k <= 8) begin
        check("stream_req", {31'd0, imem_req}, 32'd1);
        check("stream_addr", imem_addr, 32'(4 * (k - 1)));
      end
      if (k == 2) check("lat_pre", {31'd0, if_valid}, 32'd0);
      if (k >= 3 && k <= 10) check("thru_valid", {31'd0, if_valid}, 32'd1);
      if (k == 3) check("first_pc", if_pc, 32'd0);
    end

    // Decode stalled: credit limits grants to queue depth
    for (int i = 0; i < 4; i++) exp_pc.push_back(32'h20 + 32'(i * 4));
    tick(); imem_gnt = 1'b1; id_ready = 1'b0;
    ngr = 0;
    for (int k = 0; k < 10; k++) begin
      at_neg();
      if (imem_req && imem_gnt) ngr++;
      tick();
    end
    at_neg();
    check("credit_grants", ngr, 32'd4);
    check("credit_req", {31'd0, imem_req}, 32'd0);
    check("full_head_pc", if_pc, 32'h20);
    tick(); imem_gnt = 1'b0; id_ready = 1'b1;
    repeat (6) tick();

    // Redirect to 0x103 with two responses outstanding
    at_neg(); mem_hold = 1'b1;
    exp_pc.push_back(32'h100); exp_pc.push_back(32'h104);
    tick(); imem_gnt = 1'b1;
    tick();
    tick(); imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    at_neg(); mem_hold = 1'b0;
    tick(); redirect = 1'b0;
    at_neg();
    check("flush_req0", {31'd0, imem_req}, 32'd0);
    check("flush_valid", {31'd0, if_valid}, 32'd0);
    tick();
    at_neg();
    check("flush_req1", {31'd0, imem_req}, 32'd0);
    tick(); imem_gnt = 1'b1;
    at_neg();
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    tick();
    tick(); imem_gnt = 1'b0;
    repeat (5) tick();

    // Redirect coinciding with a response and a ready decode, queue nonempty
    tick(); imem_gnt = 1'b1; id_ready = 1'b0;
    tick();
    tick(); imem_gnt = 1'b0; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h180;
    at_neg();
    check("rd_mask_valid", {31'd0, if_valid}, 32'd0);
    tick(); redirect = 1'b0;
    at_neg();
    check("rd_q_empty", {31'd0, if_valid}, 32'd0);
    check("rd_req", {31'd0, imem_req}, 32'd1);
    check("rd_addr", imem_addr, 32'h180);

    // Second redirect during FLUSH
    mem_hold = 1'b1;
    exp_pc.push_back(32'h200); exp_pc.push_back(32'h204);
    tick(); imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    tick(); redirect_pc = 32'h200;
    at_neg();
    check("flush2_req0", {31'd0, imem_req}, 32'd0);
    mem_hold = 1'b0;
    tick(); redirect = 1'b0;
    at_neg();
    check("flush2_req1", {31'd0, imem_req}, 32'd0);
    tick(); imem_gnt = 1'b1;
    at_neg();
    check("redir2_req", {31'd0, imem_req}, 32'd1);
    check("redir2_addr", imem_addr, 32'h200);
    tick();
    tick(); imem_gnt = 1'b0;
    repeat (5) tick();

    // PC wrap
    exp_pc.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'h0);
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0; imem_gnt = 1'b1;
    at_neg();
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    at_neg();
    check("wrap_addr1", imem_addr, 32'h0);
    tick(); imem_gnt = 1'b0;
    repeat (5) tick();

    // Reset pulse mid-burst
    exp_pc.push_back(32'h4);
    tick(); imem_gnt = 1'b1; id_ready = 1'b1;
    tick();
    tick();
    tick();
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_req",   {31'd0, imem_req}, 32'd0);
    check("mid_rst_addr",  imem_addr, 32'd0);
    check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    check("mid_rst_instr", if_instr, 32'd0);
    check("mid_rst_pc",    if_pc, 32'd0);
    imem_gnt = 1'b0;
    tick();
    tick(); Reset = 1'b0;
    at_neg();
    check("post_rst_req0", {31'd0, imem_req}, 32'd0);
    tick();
    at_neg();
    check("post_rst_req1", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);
    check("sb_drained", exp_pc.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
